// File: rtl/fib_term_collector.sv
// Show-ahead FIFO for Fibonacci terms with a recurrence checker and sticky
// status flags (sequence error, generator saturation, dropped term).
module fib_term_collector #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [7:0]    fib_in,
    input  logic          ovf_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          seq_err,
    output logic          sat_seen,
    output logic          dropped
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {SEED0, SEED1, RUN} chk_state_e;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count_q;
    logic          term, push, pop;

    chk_state_e    state_q, state_d;
    logic [7:0]    t1_q, t2_q, t1_d, t2_d;
    logic [8:0]    sum;
    logic          seq_bad;

    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_data  = out_valid ? mem[rptr] : 8'h00;

    // Overflow terms never reach the FIFO; a full FIFO still accepts when it pops.
    assign term = in_valid & ~ovf_in;
    assign pop  = out_valid & out_ready;
    assign push = term & (~full | pop);

    // NOTE: storage has no reset; out_valid/out_data gate stale contents, so
    // clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wptr] <= fib_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED0;
            t1_q    <= 8'h00;
            t2_q    <= 8'h00;
        end else if (clr) begin
            state_q <= SEED0;
            t1_q    <= 8'h00;
            t2_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
        end
    end

    assign sum = {1'b0, t1_q} + {1'b0, t2_q};

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        seq_bad = 1'b0;
        if (term) begin
            case (state_q)
                SEED0: begin
                    t2_d    = fib_in;
                    state_d = SEED1;
                end
                SEED1: begin
                    t1_d    = t2_q;
                    t2_d    = fib_in;
                    state_d = RUN;
                end
                RUN: begin
                    seq_bad = ({1'b0, fib_in} != sum);
                    t1_d    = t2_q;
                    t2_d    = fib_in;
                end
                default: state_d = SEED0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err  <= 1'b0;
            sat_seen <= 1'b0;
            dropped  <= 1'b0;
        end else if (clr) begin
            seq_err  <= 1'b0;
            sat_seen <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            if (seq_bad)                    seq_err  <= 1'b1;
            if (in_valid && ovf_in)         sat_seen <= 1'b1;
            if (term && full && !pop)       dropped  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fib_term_collector.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a queue-based reference model of the collector.
module tb_fib_term_collector;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, ovf_in, out_ready;
    logic [7:0]    fib_in;
    logic          out_valid, full, seq_err, sat_seen, dropped;
    logic [7:0]    out_data;
    logic [CW-1:0] count;

    int tests = 0;
    int failed = 0;

    // Reference model: FIFO contents, last two accepted terms, sticky flags.
    logic [7:0] mq[$];
    int         hist[$];
    bit         m_seq, m_sat, m_drop;

    fib_term_collector #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .fib_in(fib_in), .ovf_in(ovf_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full),
        .seq_err(seq_err), .sat_seen(sat_seen), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({tag, ".out_data"},  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        check({tag, ".count"},     32'(count),     32'(mq.size()));
        check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
        check({tag, ".seq_err"},   32'(seq_err),   32'(m_seq));
        check({tag, ".sat_seen"},  32'(sat_seen),  32'(m_sat));
        check({tag, ".dropped"},   32'(dropped),   32'(m_drop));
    endtask

    task automatic model_reset();
        mq.delete();
        hist.delete();
        m_seq  = 0;
        m_sat  = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input bit c, input bit iv, input logic [7:0] f, input bit ov, input bit rdy);
        bit was_full, do_pop;
        if (c) begin
            model_reset();
            return;
        end
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && rdy;
        if (do_pop) void'(mq.pop_front());
        if (iv && ov) begin
            m_sat = 1;
        end else if (iv) begin
            if (hist.size() == 2 && int'(f) != hist[0] + hist[1]) m_seq = 1;
            hist.push_back(int'(f));
            if (hist.size() > 2) void'(hist.pop_front());
            if (!was_full || do_pop) mq.push_back(f);
            else m_drop = 1;
        end
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic cycle(input string tag, input bit c, input bit iv, input logic [7:0] f,
                         input bit ov, input bit rdy);
        @(negedge clk);
        clr = c; in_valid = iv; fib_in = f; ovf_in = ov; out_ready = rdy;
        model_step(c, iv, f, ov, rdy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push_list(input string tag, input logic [7:0] vals[$], input bit rdy);
        foreach (vals[i]) cycle(tag, 0, 1, vals[i], 0, rdy);
    endtask

    logic [7:0] seq_a[$] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8};
    logic [7:0] seq_b[$] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34};
    logic [7:0] seq_c[$] = '{8'd1, 8'd1, 8'd2, 8'd4, 8'd6};
    logic [7:0] seq_d[$] = '{8'd89, 8'd144, 8'd233};
    logic [7:0] seq_e[$] = '{8'd1, 8'd1, 8'd2};

    initial begin
        rst_n = 1'b0; clr = 0; in_valid = 0; fib_in = 8'h00; ovf_in = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) cycle("idle_after_reset", 0, 0, 8'hA5, 0, 1);

        // Clean stream with a ready consumer, then drain.
        push_list("stream_ok", seq_a, 1);
        repeat (2) cycle("stream_ok_drain", 0, 0, 8'h00, 0, 1);

        // Fill past capacity with a stalled consumer, then drain.
        cycle("clr", 1, 0, 8'h00, 0, 0);
        push_list("overfill", seq_b, 0);
        repeat (9) cycle("overfill_drain", 0, 0, 8'h00, 0, 1);

        // Full FIFO with simultaneous push and pop.
        cycle("clr", 1, 0, 8'h00, 0, 0);
        seq_b.pop_back();
        push_list("fill", seq_b, 0);
        cycle("full_push_pop", 0, 1, 8'd55, 0, 1);
        repeat (9) cycle("full_drain", 0, 0, 8'h00, 0, 1);

        // Recurrence violation.
        cycle("clr", 1, 0, 8'h00, 0, 0);
        push_list("bad_seq", seq_c, 0);
        repeat (6) cycle("bad_seq_drain", 0, 0, 8'h00, 0, 1);

        // Saturation terms are blocked, including repeats.
        cycle("clr", 1, 0, 8'h00, 0, 0);
        push_list("sat", seq_d, 0);
        cycle("sat_ovf", 0, 1, 8'hFF, 1, 0);
        cycle("sat_ovf_rep", 0, 1, 8'hFF, 1, 0);
        cycle("clr_override", 1, 1, 8'd3, 0, 1);

        // Random traffic, mostly legal terms.
        for (int n = 0; n < 400; n++) begin
            bit c, iv, ov, rdy;
            logic [7:0] f;
            c   = ($urandom_range(59) == 0);
            iv  = ($urandom_range(3) != 0);
            ov  = ($urandom_range(9) == 0);
            rdy = ($urandom_range(2) != 0);
            if (hist.size() == 2 && $urandom_range(4) != 0) f = 8'(hist[0] + hist[1]);
            else f = 8'($urandom_range(255));
            cycle("random", c, iv, f, ov, rdy);
        end

        // Asynchronous reset in the middle of a clock phase with 5 entries stored.
        cycle("clr", 1, 0, 8'h00, 0, 0);
        push_list("pre_reset", seq_a[0:4], 0);
        @(negedge clk);
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk) rst_n = 1'b1;
        cycle("post_reset_idle", 0, 0, 8'h00, 0, 1);
        push_list("post_reset", seq_e, 1);
        repeat (2) cycle("post_reset_drain", 0, 0, 8'h00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/fib_term_collector.md
FIB_TERM_COLLECTOR -- requirements
Module: fib_term_collector

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter CW, default 4, count width; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous clear of FIFO, checker and flags.
REQ-006 in_valid  input  1  fib_in/ovf_in carry a new term this cycle.
REQ-007 fib_in  input  8  Fibonacci term from the generator stage.
REQ-008 ovf_in  input  1  generator overflow/saturation indication.
REQ-009 out_valid  output  1  FIFO non-empty; out_data holds the head entry.
REQ-010 out_ready  input  1  consumer accepts the head entry when out_valid=1.
REQ-011 out_data  output  8  head FIFO entry (show-ahead).
REQ-012 count  output  CW  number of stored entries, 0..DEPTH.
REQ-013 full  output  1  count==DEPTH.
REQ-014 seq_err  output  1  sticky: a term violated the Fibonacci recurrence.
REQ-015 sat_seen  output  1  sticky: ovf_in was seen with in_valid.
REQ-016 dropped  output  1  sticky: a term was lost because the FIFO was full.

Function
REQ-017 Push condition: in_valid=1 and ovf_in=0 and (full=0 or pop this cycle).
REQ-018 Pop condition: out_valid=1 and out_ready=1; head advances at that edge.
REQ-019 Push at edge N SHALL make the entry visible on out_valid/out_data after edge N (1-cycle latency when empty).
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when full (no drop).
REQ-021 in_valid=1, ovf_in=0, full=1, no pop: term discarded, dropped<=1, count unchanged, checker still updated.
REQ-022 Pop when empty SHALL not occur (out_valid=0); out_ready ignored.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow 0.
REQ-024 out_data SHALL be 8'h00 when empty.
REQ-025 Checker states: SEED0 (no term), SEED1 (one term), RUN (two previous terms t1 older, t2 newer held).
REQ-026 SEED0 -> SEED1 on valid non-ovf term (t2<=fib_in); SEED1 -> RUN (t1<=t2, t2<=fib_in); no check in seeds.
REQ-027 In RUN, each valid non-ovf term: compute 9-bit sum t1+t2; if fib_in != sum (including sum>255) set seq_err<=1; shift t1<=t2, t2<=fib_in regardless.
REQ-028 in_valid=1 with ovf_in=1: no push, sat_seen<=1, checker state and t1/t2 unchanged.
REQ-029 Consecutive identical overflow terms SHALL not push duplicates (all ovf terms blocked).
REQ-030 in_valid=0: checker and FIFO write side hold.
REQ-031 clr=1 SHALL behave as reset on the next edge and override push/pop in that cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force: count=0, full=0, out_valid=0, out_data=8'h00, seq_err=0, sat_seen=0, dropped=0, pointers=0, checker=SEED0, t1=t2=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries; first term after release is treated as SEED0.
REQ-034 Outputs SHALL be stable from rst_n release until the first in_valid.

Verification
REQ-035 Stream 1,1,2,3,5,8 with out_ready=1 -> same 6 values on out_data in order, each 1 cycle after input, seq_err=0.
REQ-036 out_ready=0, push 9 terms (DEPTH=8) -> count=8, full=1, dropped=1 after 9th; drain yields first 8 terms.
REQ-037 Full FIFO, push and pop same cycle -> count stays 8, dropped stays 0, new term appears at tail.
REQ-038 Stream 1,1,2,4 -> seq_err=1 after 4th term; 4 still stored; next term 6 accepted with no additional effect.
REQ-039 Stream ...,144,233 then ovf_in=1 with 8'hFF -> no push, sat_seen=1, count unchanged.
REQ-040 rst_n pulsed low while count=5 mid-stream -> all outputs at reset values asynchronously; stream 1,1,2 after release checks clean.
